// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Arbitrates icache line reads and dcache line reads/write-backs
//            onto a single burst memory port, one line per 4-beat burst.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64,
    parameter int BURSTS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_address,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic [31:0]       bmem_address,
    output logic              bmem_read,
    output logic              bmem_write,
    input  logic [BEAT_W-1:0] bmem_rdata,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_resp
);

    localparam int CNT_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURSTS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_RD = 3'd1,
        D_RD = 3'd2,
        D_WR = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   side_q, side_d;     // 1 = dcache owns the burst
    logic                   last_q, last_d;     // 1 = dcache was granted last
    logic [31-OFF_W:0]      addr_q, addr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [LINE_W-1:0]      line_q, line_d;

    logic                   w_i_pend;
    logic                   w_d_pend;
    logic                   w_pick_d;
    logic                   w_unused;

    assign w_i_pend = i_read;
    assign w_d_pend = d_read | d_write;
    // On a tie the side that did not win last time takes the bus.
    assign w_pick_d = w_d_pend && (!w_i_pend || !last_q);
    assign w_unused = ^{i_address[OFF_W-1:0], d_address[OFF_W-1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            side_q  <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        side_d  = side_q;
        last_d  = last_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        case (state_q)
            IDLE: begin
                if (w_i_pend || w_d_pend) begin
                    side_d = w_pick_d;
                    last_d = w_pick_d;
                    cnt_d  = '0;
                    addr_d = w_pick_d ? d_address[31:OFF_W] : i_address[31:OFF_W];
                    if (!w_pick_d) begin
                        state_d = I_RD;
                    end else if (d_write) begin
                        state_d = D_WR;
                    end else begin
                        state_d = D_RD;
                    end
                end
            end
            I_RD, D_RD, D_WR: begin
                if (bmem_resp) begin
                    if (state_q != D_WR) begin
                        for (int k = 0; k < BURSTS; k++) begin
                            if (cnt_q == CNT_W'(k)) begin
                                line_d[k*BEAT_W +: BEAT_W] = bmem_rdata;
                            end
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bmem_wdata = '0;
        if (state_q == D_WR) begin
            for (int k = 0; k < BURSTS; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    bmem_wdata = d_wdata[k*BEAT_W +: BEAT_W];
                end
            end
        end
    end

    assign bmem_read    = (state_q == I_RD) || (state_q == D_RD);
    assign bmem_write   = (state_q == D_WR);
    assign bmem_address = {addr_q, {OFF_W{1'b0}}};
    assign i_resp       = (state_q == DONE) && !side_q;
    assign d_resp       = (state_q == DONE) &&  side_q;
    assign i_rdata      = line_q;
    assign d_rdata      = line_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): LINE_W, 256, cache line width in bits; BEAT_W, 64, burst-memory beat width in bits; BURSTS, 4, beats per line (LINE_W/BEAT_W).
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 i_address  in  32  icache line-miss address.
REQ-006 i_read  in  1  icache line read request.
REQ-007 i_rdata  out  256  line returned to icache.
REQ-008 i_resp  out  1  icache transfer complete, one-cycle pulse.
REQ-009 d_address  in  32  dcache line address.
REQ-010 d_read  in  1  dcache line read (fill) request.
REQ-011 d_write  in  1  dcache line write-back request.
REQ-012 d_wdata  in  256  write-back line, held stable by dcache until d_resp.
REQ-013 d_rdata  out  256  line returned to dcache.
REQ-014 d_resp  out  1  dcache transfer complete, one-cycle pulse.
REQ-015 bmem_address  out  32  line-aligned burst address.
REQ-016 bmem_read  out  1  burst read request, held for whole burst.
REQ-017 bmem_write  out  1  burst write request, held for whole burst.
REQ-018 bmem_rdata  in  64  read beat.
REQ-019 bmem_wdata  out  64  write beat.
REQ-020 bmem_resp  in  1  beat accepted/valid.

Function
REQ-021 FSM states SHALL be IDLE, I_RD, D_RD, D_WR, DONE; all outputs decoded from registered state (Moore), no combinational requester-to-bmem path.
REQ-022 IDLE: d_write SHALL win over d_read if both high (illegal combination, tolerated).
REQ-023 IDLE arbitration: only icache pending -> I_RD; only dcache pending -> D_RD/D_WR; both pending -> grant the side NOT granted last (1-bit last_grant flop, updated on every grant).
REQ-024 Granted requester index and address SHALL be latched on grant; bmem_address = {latched_addr[31:5], 5'b0}.
REQ-025 bmem_read SHALL be 1 exactly in I_RD and D_RD; bmem_write exactly in D_WR; never both.
REQ-026 2-bit beat counter SHALL clear on grant, increment on each bmem_resp in I_RD/D_RD/D_WR.
REQ-027 Read beat k (counter value) SHALL be written into line buffer bits [64k+63:64k] on bmem_resp.
REQ-028 bmem_wdata SHALL equal d_wdata[64k+63:64k] for current counter k in D_WR; 0 otherwise.
REQ-029 bmem_resp with counter==3 SHALL move state to DONE and wrap counter to 0.
REQ-030 DONE lasts exactly one cycle: assert i_resp or d_resp (granted side only), then IDLE.
REQ-031 i_rdata and d_rdata SHALL both present the line buffer continuously; valid only while respective resp high.
REQ-032 Latency: grant edge -> bmem request next cycle; resp = 1 cycle after 4th bmem_resp; min request-to-resp 6 cycles with zero-wait memory.
REQ-033 Requesters SHALL drop request the cycle after resp; arbiter re-samples in IDLE so back-to-back requests lose at most one cycle.
REQ-034 Requests changing while not IDLE SHALL be ignored until IDLE; bmem_resp in IDLE/DONE ignored.
REQ-035 Requests never dropped: a pending loser SHALL be granted at the next IDLE.

Reset
REQ-036 rst low SHALL immediately force state IDLE, counter 0, last_grant = icache (so dcache wins first tie), line buffer 0, all resp/bmem_read/bmem_write 0, bmem_address 0.
REQ-037 Reset mid-burst SHALL abort the burst with no resp pulse; first request after release restarts from beat 0.

Verification
REQ-038 i_read, i_address=0x0000_1234, memory returns beats A,B,C,D zero-wait -> bmem_address=0x0000_1220, i_resp one cycle, i_rdata={D,C,B,A}, d_resp stays 0.
REQ-039 d_write, d_wdata={W3,W2,W1,W0}, 2-cycle wait per beat -> bmem_wdata sequence W0,W1,W2,W3, bmem_write held 8+ cycles, single d_resp.
REQ-040 i_read and d_read asserted same cycle after reset -> dcache served first, icache second with one IDLE cycle between; repeat tie -> order alternates.
REQ-041 d_read and d_write both high -> write burst issued, bmem_read never asserted.
REQ-042 rst low after 2 read beats -> outputs zero asynchronously; new i_read after release -> full 4-beat burst, correct line, one i_resp.
REQ-043 Spurious bmem_resp in IDLE -> no state change, no resp, counter stays 0.
